microwave_timer_ctrl: RTL and testbench
=======================================

# microwave_timer_ctrl

Sequencing controller for the cooking timer's cascade of four `counter_down10` BCD digits (MM:SS style, four decimal digits).
- Collects keypad digits into a preset register.
- Loads the preset into the counter cascade.
- Gates count-down enables from the 1 Hz tick.
- Handles start, pause, resume and clear, plus door interlock.
- Drives heat and done indications.

It sits between the debounced front-panel inputs and the counter cascade in the timer level.

## Interface
- DONE_TICKS, 3: number of tick pulses that `done` stays asserted before auto-return to IDLE.
- clk  in  1  system clock, all state updates on rising edge.
- rst  in  1  synchronous, active-low reset.
- key_valid  in  1  one-cycle strobe, keypad digit present.
- key_digit  in  4  keypad digit; values above 9 are ignored.
- start  in  1  one-cycle strobe, start/resume.
- stop  in  1  one-cycle strobe, pause.
- clear  in  1  one-cycle strobe, cancel and clear.
- door_closed  in  1  1 = door closed (interlock satisfied).
- tick  in  1  one-cycle pulse at count rate (1 Hz).
- cnt_zero  in  1  1 when all four counter digits read 0 (from cascade).
- load  out  1  one-cycle load strobe to counters (Mealy).
- enablen  out  1  active-low count enable to counters (Mealy).
- preset  out  16  four BCD digits, [15:12] MSD, to counters' `in`.
- heat_on  out  1  magnetron enable (Moore).
- done  out  1  cooking-finished indication (Moore).
- state  out  3  FSM state, for display/debug.

## Operation
- States and encodings: IDLE=0, ENTRY=1, RUN=2, PAUSE=3, DONE=4. Encodings 5-7 are illegal and go to IDLE on the next edge.
- Input priority in every state: clear, then stop / door open, then start, then key_valid.
- IDLE:
  - `preset`=0.
  - A valid key (digit ≤ 9) shifts it in: `preset <= {preset[11:0], key_digit}`. Next state is ENTRY.
- ENTRY:
  - Further valid keys shift the same way; the MSD is discarded once four digits have been entered.
  - clear: `preset` becomes 0 and the FSM goes to IDLE.
  - start with door_closed=1 and preset≠0: `load`=1 in that cycle and the FSM goes to RUN. The counters capture `preset` on the same edge.
  - start with preset=0 or the door open is ignored.
- RUN:
  - heat_on=1.
  - `enablen` = !(tick && !cnt_zero && !stop && door_closed && !clear).
  - cnt_zero=1 goes to DONE; no further enables are issued.
  - stop or door_closed=0 goes to PAUSE.
  - clear: `load`=1 with `preset` forced to 0 in that cycle. `preset` register becomes 0 and the FSM goes to IDLE.
- PAUSE:
  - heat_on=0 and enablen=1.
  - start with door_closed=1 goes to RUN without reload, resuming from the held count.
  - clear behaves as in RUN: a zero load, then IDLE.
- DONE:
  - done=1, heat_on=0, enablen=1.
  - An internal counter counts tick pulses; on the DONE_TICKS-th tick the FSM goes to IDLE.
  - start, stop, clear or a door open goes to IDLE immediately.
  - `preset` is cleared on the exit.
- Keys are ignored in RUN, PAUSE and DONE.
- `load` and `enablen`=0 are never asserted in the same cycle.
- `load` is asserted only on the ENTRY→RUN transition or on a clear from RUN/PAUSE.

## Timing
- Reset values when rst=0 at an edge:
  - state=IDLE, preset=0, done counter=0.
  - Outputs settle to load=0, enablen=1, heat_on=0, done=0.
- Reset mid-RUN:
  - Heat drops in the cycle after the reset edge.
  - The counters are reset by the same `rst`; this block issues no load.
- Latency:
  - key_valid → `preset` updated at the next edge.
  - start → RUN at the next edge; heat_on is high from the first RUN cycle.
  - load is combinational in the start cycle.
- Decrement: `enablen` is low only during the tick cycle, so each tick decrements by exactly one count.
- cnt_zero is observed in RUN; the transition to DONE happens at the edge after cnt_zero first reads 1.
  - A tick arriving while cnt_zero=1 does not decrement, so there is no wrap to 9999.
- Tick with stop in the same cycle: stop wins, there is no decrement, and the FSM goes to PAUSE.
- Door opening during RUN: enablen is forced high combinationally in that same cycle.
- The DONE tick counter is cleared on DONE entry.

## Test plan
- Reset, then keys 1,2,3,4,5 → preset=0x2345 and state=ENTRY. Then clear → preset=0 and state=IDLE.
- Keys 0,3 and start with door closed → load=1 for one cycle with preset=0x0003 and state=RUN. Three ticks → three enablen-low cycles, then DONE. done stays high until the 3rd subsequent tick, then IDLE.
- RUN with preset 0x0010 and 2 ticks, then door open → PAUSE with heat_on=0. Tick while paused → enablen stays 1. Door closed plus start → RUN with no load pulse.
- Tick and stop in the same cycle in RUN → enablen=1 in that cycle and state=PAUSE.
- Start with preset=0 or with the door open → no load and state stays ENTRY/IDLE. Key 0xA → preset unchanged.
- rst=0 while in RUN → next cycle: state=IDLE, heat_on=0, done=0, enablen=1, preset=0. Clear from PAUSE → load=1 with preset bus 0x0000.

Source files
------------

// File: rtl/microwave_timer_ctrl.sv
// microwave_timer_ctrl
// Sequencing controller for a four-digit BCD cooking timer. Collects keypad
// digits into a preset, loads the preset into an external down-counter
// cascade, gates the cascade's count enable from the 1 Hz tick, and handles
// start / pause / resume / clear, the door interlock and the done indication.
//
// Ports
//   i_clk          system clock, rising edge
//   i_rst          synchronous reset, active low
//   i_key_valid    one-cycle strobe, keypad digit present
//   i_key_digit    keypad digit (values above 9 ignored)
//   i_start        one-cycle strobe, start / resume
//   i_stop         one-cycle strobe, pause
//   i_clear        one-cycle strobe, cancel and clear
//   i_door_closed  1 = door closed
//   i_tick         one-cycle pulse at count rate
//   i_cnt_zero     1 when the counter cascade reads 0000
//   o_load         load strobe to the cascade
//   o_enablen      active-low count enable to the cascade
//   o_preset       BCD value presented to the cascade, [15:12] MSD
//   o_heat_on      magnetron enable
//   o_done         cooking finished
//   o_state        FSM state for display/debug
//
// state | meaning
// IDLE  | nothing entered, preset is zero
// ENTRY | digits being collected into the preset
// RUN   | cooking, heat on, ticks decrement the cascade
// PAUSE | held count, heat off, waiting for resume
// DONE  | finished, done shown for DONE_TICKS ticks

module microwave_timer_ctrl #(
    parameter int DONE_TICKS = 3
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_key_valid,
    input  logic [3:0]  i_key_digit,
    input  logic        i_start,
    input  logic        i_stop,
    input  logic        i_clear,
    input  logic        i_door_closed,
    input  logic        i_tick,
    input  logic        i_cnt_zero,
    output logic        o_load,
    output logic        o_enablen,
    output logic [15:0] o_preset,
    output logic        o_heat_on,
    output logic        o_done,
    output logic [2:0]  o_state
);

    localparam int CW = (DONE_TICKS > 1) ? $clog2(DONE_TICKS) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ENTRY = 3'd1,
        S_RUN   = 3'd2,
        S_PAUSE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [15:0]     r_preset;
    logic [15:0]     w_preset_nxt;
    logic [CW-1:0]   r_done_cnt;
    logic [CW-1:0]   w_done_cnt_nxt;
    logic            w_key_ok;
    logic            w_door_open;

    assign w_key_ok    = i_key_valid && (i_key_digit <= 4'd9);
    assign w_door_open = !i_door_closed;
    assign o_state     = r_state;

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state    <= S_IDLE;
            r_preset   <= 16'h0000;
            r_done_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_preset   <= w_preset_nxt;
            r_done_cnt <= w_done_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_preset_nxt   = r_preset;
        w_done_cnt_nxt = r_done_cnt;
        o_load         = 1'b0;
        o_enablen      = 1'b1;
        o_preset       = r_preset;
        o_heat_on      = 1'b0;
        o_done         = 1'b0;

        case (r_state)
            S_IDLE, S_ENTRY: begin
                if (i_clear) begin
                    w_preset_nxt = 16'h0000;
                    w_state_nxt  = S_IDLE;
                end else if (i_start && i_door_closed && (r_preset != 16'h0000)) begin
                    // counters capture o_preset on the same edge we enter RUN
                    o_load      = 1'b1;
                    w_state_nxt = S_RUN;
                end else if (w_key_ok) begin
                    w_preset_nxt = {r_preset[11:0], i_key_digit};
                    w_state_nxt  = S_ENTRY;
                end
            end

            S_RUN: begin
                o_heat_on = 1'b1;
                // a tick at zero must not decrement, otherwise the cascade wraps to 9999
                o_enablen = !(i_tick && !i_cnt_zero && !i_stop && i_door_closed && !i_clear);
                if (i_clear) begin
                    o_load       = 1'b1;
                    o_preset     = 16'h0000;
                    w_preset_nxt = 16'h0000;
                    w_state_nxt  = S_IDLE;
                end else if (i_stop || w_door_open) begin
                    w_state_nxt = S_PAUSE;
                end else if (i_cnt_zero) begin
                    w_done_cnt_nxt = '0;
                    w_state_nxt    = S_DONE;
                end
            end

            S_PAUSE: begin
                if (i_clear) begin
                    o_load       = 1'b1;
                    o_preset     = 16'h0000;
                    w_preset_nxt = 16'h0000;
                    w_state_nxt  = S_IDLE;
                end else if (i_stop || w_door_open) begin
                    w_state_nxt = S_PAUSE;
                end else if (i_start) begin
                    w_state_nxt = S_RUN;
                end
            end

            S_DONE: begin
                o_done = 1'b1;
                if (i_clear || i_stop || w_door_open || i_start) begin
                    w_preset_nxt = 16'h0000;
                    w_state_nxt  = S_IDLE;
                end else if (i_tick) begin
                    if (r_done_cnt == CW'(DONE_TICKS - 1)) begin
                        w_preset_nxt   = 16'h0000;
                        w_done_cnt_nxt = '0;
                        w_state_nxt    = S_IDLE;
                    end else begin
                        w_done_cnt_nxt = r_done_cnt + CW'(1);
                    end
                end
            end

            default: begin
                w_preset_nxt   = 16'h0000;
                w_done_cnt_nxt = '0;
                w_state_nxt    = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_microwave_timer_ctrl.sv
// Bench for microwave_timer_ctrl: directed scenarios plus a randomized run,
// all compared against a digit-queue / integer-seconds reference model and a
// BCD counter cascade plant driven by the DUT's load/enable outputs.

module tb_microwave_timer_ctrl;

    localparam int DT = 3;
    localparam int M_IDLE = 0, M_ENTRY = 1, M_RUN = 2, M_PAUSE = 3, M_DONE = 4;

    logic        clk = 1'b0;
    logic        rst, key_valid, start, stop, clear, door_closed, tick, cnt_zero;
    logic [3:0]  key_digit;
    logic        load, enablen, heat_on, done;
    logic [15:0] preset;
    logic [2:0]  state;

    always #5 clk = ~clk;

    microwave_timer_ctrl #(.DONE_TICKS(DT)) dut (
        .i_clk(clk), .i_rst(rst), .i_key_valid(key_valid), .i_key_digit(key_digit),
        .i_start(start), .i_stop(stop), .i_clear(clear), .i_door_closed(door_closed),
        .i_tick(tick), .i_cnt_zero(cnt_zero), .o_load(load), .o_enablen(enablen),
        .o_preset(preset), .o_heat_on(heat_on), .o_done(done), .o_state(state)
    );

    int checks = 0;
    int errors = 0;

    // counter cascade plant
    logic [15:0] p_cnt;

    function automatic logic [15:0] bcd_dec(input logic [15:0] v);
        logic [15:0] r;
        logic        borrow;
        r = v;
        borrow = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (borrow) begin
                if (r[4*i +: 4] == 4'd0) r[4*i +: 4] = 4'd9;
                else begin
                    r[4*i +: 4] = r[4*i +: 4] - 4'd1;
                    borrow = 1'b0;
                end
            end
        end
        return r;
    endfunction

    always @(posedge clk) begin
        if (!rst)         p_cnt <= 16'h0000;
        else if (load)    p_cnt <= preset;
        else if (!enablen) p_cnt <= bcd_dec(p_cnt);
    end
    assign cnt_zero = (p_cnt == 16'h0000);

    // reference model
    int m_mode;
    int m_digits[$];
    int m_dticks;
    int m_secs;

    logic        e_load, e_enablen, e_heat, e_done;
    logic [15:0] e_preset;
    logic [2:0]  e_state;

    function automatic int preset_val();
        int v = 0;
        foreach (m_digits[i]) v = v * 16 + m_digits[i];
        return v;
    endfunction

    function automatic int bcd_to_int(input logic [15:0] b);
        return int'(b[15:12]) * 1000 + int'(b[11:8]) * 100 + int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    function automatic logic [15:0] to_bcd(input int n);
        return 16'(((n / 1000) % 10) * 4096 + ((n / 100) % 10) * 256 + ((n / 10) % 10) * 16 + n % 10);
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE;
        m_digits.delete();
        m_dticks = 0;
        m_secs = 0;
    endtask

    task automatic compute_expect();
        int  pv;
        logic running_or_paused;
        pv = preset_val();
        running_or_paused = (m_mode == M_RUN) || (m_mode == M_PAUSE);
        e_load = ((m_mode == M_IDLE || m_mode == M_ENTRY) && !clear && start && door_closed && pv != 0)
                 || (running_or_paused && clear);
        e_enablen = !(m_mode == M_RUN && tick && !cnt_zero && !stop && door_closed && !clear);
        e_preset = (running_or_paused && clear) ? 16'h0000 : 16'(pv);
        e_heat = (m_mode == M_RUN);
        e_done = (m_mode == M_DONE);
        e_state = 3'(m_mode);
    endtask

    task automatic model_update();
        int pv;
        pv = preset_val();
        if (e_load) m_secs = bcd_to_int(e_preset);
        else if (!e_enablen && m_secs > 0) m_secs = m_secs - 1;
        case (m_mode)
            M_IDLE, M_ENTRY: begin
                if (clear) begin
                    m_digits.delete();
                    m_mode = M_IDLE;
                end else if (start && door_closed && pv != 0) begin
                    m_mode = M_RUN;
                end else if (key_valid && key_digit <= 4'd9) begin
                    m_digits.push_back(int'(key_digit));
                    if (m_digits.size() > 4) void'(m_digits.pop_front());
                    m_mode = M_ENTRY;
                end
            end
            M_RUN: begin
                if (clear) begin
                    m_digits.delete();
                    m_mode = M_IDLE;
                end else if (stop || !door_closed) m_mode = M_PAUSE;
                else if (cnt_zero) begin
                    m_mode = M_DONE;
                    m_dticks = 0;
                end
            end
            M_PAUSE: begin
                if (clear) begin
                    m_digits.delete();
                    m_mode = M_IDLE;
                end else if (!stop && door_closed && start) m_mode = M_RUN;
            end
            default: begin
                if (clear || stop || !door_closed || start) begin
                    m_digits.delete();
                    m_mode = M_IDLE;
                end else if (tick) begin
                    m_dticks++;
                    if (m_dticks == DT) begin
                        m_digits.delete();
                        m_mode = M_IDLE;
                    end
                end
            end
        endcase
        if (!rst) model_reset();
    endtask

    task automatic apply(input logic kv, input logic [3:0] kd, input logic st, input logic sp,
                         input logic cl, input logic tk);
        key_valid = kv; key_digit = kd; start = st; stop = sp; clear = cl; tick = tk;
        @(negedge clk);
        compute_expect();
    endtask

    task automatic adv();
        model_update();
        @(posedge clk);
        #1;
        key_valid = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0; tick = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; door_closed = 1'b1;
        key_valid = 1'b0; key_digit = 4'd0; start = 1'b0; stop = 1'b0; clear = 1'b0; tick = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", state); end
        checks++; if (preset !== 16'h0) begin errors++; $display("FAIL reset_preset got %h exp 0000", preset); end
        checks++; if (load !== 1'b0 || enablen !== 1'b1) begin errors++; $display("FAIL reset_load_en got load=%b en=%b exp 0/1", load, enablen); end
        checks++; if (heat_on !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_heat_done got %b/%b exp 0/0", heat_on, done); end
        compute_expect();
        adv();
    endtask

    task automatic test_entry_clear();
        for (int d = 1; d <= 5; d++) begin
            apply(1'b1, 4'(d), 1'b0, 1'b0, 1'b0, 1'b0);
            adv();
        end
        apply(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (preset !== 16'h2345) begin errors++; $display("FAIL entry_preset got %h exp 2345", preset); end
        checks++; if (state !== 3'd1) begin errors++; $display("FAIL entry_state got %0d exp 1", state); end
        adv();
        apply(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        checks++; if (load !== 1'b0) begin errors++; $display("FAIL entry_clear_load got %b exp 0", load); end
        adv();
        apply(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (preset !== 16'h0 || state !== 3'd0) begin errors++; $display("FAIL entry_clear got preset=%h state=%0d exp 0000/0", preset, state); end
        adv();
    endtask

    task automatic test_run_done();
        door_closed = 1'b1;
        apply(1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0); adv();
        apply(1'b1, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0); adv();
        apply(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++; if (load !== 1'b1 || preset !== 16'h0003 || enablen !== 1'b1) begin errors++; $display("FAIL start_load got load=%b preset=%h en=%b exp 1/0003/1", load, preset, enablen); end
        adv();
        for (int i = 0; i < 3; i++) begin
            apply(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
            checks++; if (state !== 3'd2 || heat_on !== 1'b1 || enablen !== 1'b1) begin errors++; $display("FAIL run_idle got state=%0d heat=%b en=%b exp 2/1/1", state, heat_on, enablen); end
            adv();
            apply(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
            checks++; if (enablen !== 1'b0) begin errors++; $display("FAIL run_tick_en got %b exp 0", enablen); end
            adv();
        end
        apply(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        checks++; if (state !== 3'd2 || enablen !== 1'b1) begin errors++; $display("FAIL tick_at_zero got state=%0d en=%b exp 2/1", state, enablen); end
        adv();
        apply(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (state !== 3'd4 || done !== 1'b1 || heat_on !== 1'b0) begin errors++; $display("FAIL enter_done got state=%0d done=%b heat=%b exp 4/1/0", state, done, heat_on); end
        checks++; if (p_cnt !== 16'h0000) begin errors++; $display("FAIL no_wrap got %h exp 0000", p_cnt); end
        adv();
        for (int i = 0; i < DT; i++) begin
            apply(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
            checks++; if (done !== 1'b1) begin errors++; $display("FAIL done_hold got %b exp 1 at tick %0d", done, i); end
            adv();
            apply(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
            checks++; if (state !== ((i < DT - 1) ? 3'd4 : 3'd0)) begin errors++; $display("FAIL done_exit got state=%0d after tick %0d", state, i); end
            adv();
        end
    endtask

    task automatic test_pause_stop_clear();
        door_closed = 1'b1;
        apply(1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0); adv();
        apply(1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0); adv();
        apply(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0); adv();
        repeat (2) begin
            apply(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1); adv();
        end
        door_closed = 1'b0;
        apply(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        checks++; if (enablen !== 1'b1) begin errors++; $display("FAIL door_open_en got %b exp 1", enablen); end
        adv();
        apply(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        checks++; if (state !== 3'd3 || heat_on !== 1'b0 || enablen !== 1'b1) begin errors++; $display("FAIL pause got state=%0d heat=%b en=%b exp 3/0/1", state, heat_on, enablen); end
        adv();
        door_closed = 1'b1;
        apply(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++; if (load !== 1'b0) begin errors++; $display("FAIL resume_load got %b exp 0", load); end
        adv();
        apply(1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        checks++; if (state !== 3'd2 || enablen !== 1'b1) begin errors++; $display("FAIL stop_tick got state=%0d en=%b exp 2/1", state, enablen); end
        adv();
        apply(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (state !== 3'd3 || p_cnt !== 16'h0008) begin errors++; $display("FAIL held_count got state=%0d cnt=%h exp 3/0008", state, p_cnt); end
        adv();
        apply(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        checks++; if (load !== 1'b1 || preset !== 16'h0000) begin errors++; $display("FAIL pause_clear got load=%b preset=%h exp 1/0000", load, preset); end
        adv();
        apply(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (state !== 3'd0 || p_cnt !== 16'h0000) begin errors++; $display("FAIL clear_idle got state=%0d cnt=%h exp 0/0000", state, p_cnt); end
        adv();
    endtask

    task automatic test_ignored();
        door_closed = 1'b1;
        apply(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++; if (load !== 1'b0) begin errors++; $display("FAIL idle_start got load=%b exp 0", load); end
        adv();
        apply(1'b1, 4'hA, 1'b0, 1'b0, 1'b0, 1'b0); adv();
        apply(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (state !== 3'd0 || preset !== 16'h0) begin errors++; $display("FAIL idle_keyA got state=%0d preset=%h exp 0/0000", state, preset); end
        adv();
        apply(1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0); adv();
        apply(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++; if (load !== 1'b0 || state !== 3'd1) begin errors++; $display("FAIL zero_start got load=%b state=%0d exp 0/1", load, state); end
        adv();
        apply(1'b1, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0); adv();
        door_closed = 1'b0;
        apply(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++; if (load !== 1'b0) begin errors++; $display("FAIL door_start got load=%b exp 0", load); end
        adv();
        door_closed = 1'b1;
        apply(1'b1, 4'hC, 1'b0, 1'b0, 1'b0, 1'b0); adv();
        apply(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (state !== 3'd1 || preset !== 16'h0005) begin errors++; $display("FAIL entry_keyC got state=%0d preset=%h exp 1/0005", state, preset); end
        adv();
    endtask

    task automatic test_reset_run();
        logic [3:0] d;
        d = 4'($urandom_range(1, 9));
        door_closed = 1'b1;
        apply(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0); adv();
        apply(1'b1, d, 1'b0, 1'b0, 1'b0, 1'b0); adv();
        apply(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0); adv();
        rst = 1'b0;
        apply(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (heat_on !== 1'b1 || load !== 1'b0) begin errors++; $display("FAIL rst_cycle got heat=%b load=%b exp 1/0", heat_on, load); end
        adv();
        rst = 1'b1;
        apply(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (state !== 3'd0 || heat_on !== 1'b0 || done !== 1'b0 || enablen !== 1'b1 || preset !== 16'h0)
            begin errors++; $display("FAIL rst_run got state=%0d heat=%b done=%b en=%b preset=%h exp 0/0/0/1/0000", state, heat_on, done, enablen, preset); end
        adv();
    endtask

    task automatic test_random();
        door_closed = 1'b1;
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 39) == 0) door_closed = ~door_closed;
            apply(($urandom_range(0, 3) == 0), 4'($urandom_range(0, 15)), ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 39) == 0), ($urandom_range(0, 59) == 0), ($urandom_range(0, 2) == 0));
            checks++;
            if (load !== e_load || enablen !== e_enablen || preset !== e_preset || heat_on !== e_heat ||
                done !== e_done || state !== e_state || p_cnt !== to_bcd(m_secs)) begin
                errors++;
                $display("FAIL rand_%0d got load=%b en=%b preset=%h heat=%b done=%b state=%0d cnt=%h exp %b/%b/%h/%b/%b/%0d/%h",
                         n, load, enablen, preset, heat_on, done, state, p_cnt,
                         e_load, e_enablen, e_preset, e_heat, e_done, e_state, to_bcd(m_secs));
            end
            adv();
        end
    endtask

    initial begin
        test_reset();
        test_entry_clear();
        test_run_done();
        test_pause_stop_clear();
        test_ignored();
        test_reset_run();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
